// File: rtl/uart_tx_arbiter.sv
// Three-requester round-robin arbiter that feeds one UART transmit FIFO.
// Whole messages are granted; release happens on Last, on a request drop, or on an idle timeout.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [2:0]            Request,
    input  logic [2:0]            Valid,
    input  logic [2:0]            Last,
    input  logic [DATA_WIDTH-1:0] Data0,
    input  logic [DATA_WIDTH-1:0] Data1,
    input  logic [DATA_WIDTH-1:0] Data2,
    input  logic                  tx_full,
    output logic [2:0]            Grant,
    output logic [2:0]            Ready,
    output logic                  write_to_uart,
    output logic [DATA_WIDTH-1:0] uart_data,
    output logic                  Busy,
    output logic                  TimeoutFlag
);

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                             state, state_nxt;
    logic [1:0]                         gidx, gidx_nxt;
    logic [1:0]                         ptr, ptr_nxt;
    logic [7:0]                         idle_cnt, idle_cnt_nxt;
    logic [NUM_REQ-1:0]                 grant_nxt;
    logic                               wr_nxt, tf_nxt;
    logic [DATA_WIDTH-1:0]              data_nxt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
    logic                               accept, hit_limit, req_drop, go_rel;
    logic [1:0]                         pick;
    logic                               found;
    logic [2:0]                         sum;
    logic [1:0]                         cand;

    assign data_arr  = {Data2, Data1, Data0};

    // The write strobe doubles as a throttle: at most one acceptance per two cycles.
    assign accept    = (state == SEND) && Valid[gidx] && !tx_full && !write_to_uart;
    assign hit_limit = (idle_cnt == 8'(IDLE_TIMEOUT - 1));
    assign req_drop  = !Request[gidx];
    assign Busy      = (state != IDLE);

    always_comb begin
        Ready = '0;
        if (accept) Ready[gidx] = 1'b1;
    end

    // Round-robin search starting at ptr, wrapping modulo 3.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum  = {1'b0, ptr} + 3'(i);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && Request[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        gidx_nxt     = gidx;
        ptr_nxt      = ptr;
        idle_cnt_nxt = idle_cnt;
        grant_nxt    = Grant;
        tf_nxt       = 1'b0;
        wr_nxt       = accept;
        data_nxt     = accept ? data_arr[gidx] : uart_data;
        go_rel       = 1'b0;
        case (state)
            IDLE: begin
                idle_cnt_nxt = '0;
                if (|Request) begin
                    state_nxt       = SEND;
                    gidx_nxt        = pick;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                end
            end
            SEND: begin
                idle_cnt_nxt = accept ? 8'd0 : idle_cnt + 8'd1;
                // An accepted character always wins over drop/timeout; its write still goes out.
                if (accept && Last[gidx]) begin
                    go_rel = 1'b1;
                end else if (req_drop) begin
                    go_rel = 1'b1;
                end else if (hit_limit && !accept) begin
                    go_rel = 1'b1;
                    tf_nxt = 1'b1;
                end
                if (go_rel) begin
                    state_nxt = RELEASE;
                    grant_nxt = '0;
                    ptr_nxt   = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            gidx          <= '0;
            ptr           <= '0;
            idle_cnt      <= '0;
            Grant         <= '0;
            write_to_uart <= 1'b0;
            uart_data     <= '0;
            TimeoutFlag   <= 1'b0;
        end else begin
            state         <= state_nxt;
            gidx          <= gidx_nxt;
            ptr           <= ptr_nxt;
            idle_cnt      <= idle_cnt_nxt;
            Grant         <= grant_nxt;
            write_to_uart <= wr_nxt;
            uart_data     <= data_nxt;
            TimeoutFlag   <= tf_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; expected values are hand-derived per scenario.
module tb_uart_tx_arbiter;

    logic       Clock;
    logic       Reset;
    logic [2:0] Request, Valid, Last;
    logic [7:0] Data0, Data1, Data2;
    logic       tx_full;
    logic [2:0] Grant, Ready;
    logic       write_to_uart;
    logic [7:0] uart_data;
    logic       Busy, TimeoutFlag;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx_arbiter #(.DATA_WIDTH(8), .IDLE_TIMEOUT(16)) dut (
        .Clock(Clock), .Reset(Reset), .Request(Request), .Valid(Valid), .Last(Last),
        .Data0(Data0), .Data1(Data1), .Data2(Data2), .tx_full(tx_full),
        .Grant(Grant), .Ready(Ready), .write_to_uart(write_to_uart),
        .uart_data(uart_data), .Busy(Busy), .TimeoutFlag(TimeoutFlag)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clr_in();
        Request = '0; Valid = '0; Last = '0; tx_full = 1'b0;
        Data0 = '0; Data1 = '0; Data2 = '0;
    endtask

    task automatic do_reset();
        clr_in();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    logic [2:0] exp_g [4];
    logic [7:0] exp_d [4];

    initial begin
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_d = '{8'h10, 8'h20, 8'h30, 8'h10};
        clr_in();
        Reset = 1'b0;
        repeat (2) tick();
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_wr",    32'(write_to_uart), 0);
        chk("rst_data",  32'(uart_data), 0);
        chk("rst_tf",    32'(TimeoutFlag), 0);
        chk("rst_busy",  32'(Busy), 0);
        chk("rst_ready", 32'(Ready), 0);
        Reset = 1'b1;

        // Two-character message from requester 0
        Request = 3'b001; Valid = 3'b001; Data0 = 8'h41;
        tick();
        chk("m1_grant", 32'(Grant), 1);
        chk("m1_busy",  32'(Busy), 1);
        chk("m1_wr0",   32'(write_to_uart), 0);
        #1 chk("m1_rdyA", 32'(Ready), 1);
        tick();
        chk("m1_wrA",   32'(write_to_uart), 1);
        chk("m1_datA",  32'(uart_data), 'h41);
        Data0 = 8'h42; Last = 3'b001;
        #1 chk("m1_rdy_gap", 32'(Ready), 0);
        tick();
        chk("m1_wr_gap",  32'(write_to_uart), 0);
        chk("m1_hold",    32'(uart_data), 'h41);
        #1 chk("m1_rdyB", 32'(Ready), 1);
        tick();
        chk("m1_wrB",   32'(write_to_uart), 1);
        chk("m1_datB",  32'(uart_data), 'h42);
        chk("m1_rel_g", 32'(Grant), 0);
        chk("m1_rel_b", 32'(Busy), 1);
        clr_in();
        tick();
        chk("m1_idle",  32'(Busy), 0);
        chk("m1_wr_end", 32'(write_to_uart), 0);

        // All three requesting, single-character messages
        do_reset();
        Request = 3'b111; Valid = 3'b111; Last = 3'b111;
        Data0 = 8'h10; Data1 = 8'h20; Data2 = 8'h30;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", 32'(Grant), 32'(exp_g[k]));
            tick();
            chk("rr_wr",    32'(write_to_uart), 1);
            chk("rr_data",  32'(uart_data), 32'(exp_d[k]));
            chk("rr_rel",   32'(Grant), 0);
            if (k == 3) clr_in();
            tick();
        end

        // tx_full backpressure on requester 1
        do_reset();
        Request = 3'b010; Valid = 3'b010; Last = 3'b010; Data1 = 8'h5A; tx_full = 1'b1;
        tick();
        chk("bp_grant", 32'(Grant), 2);
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_ready", 32'(Ready), 0);
            tick();
            chk("bp_nowr", 32'(write_to_uart), 0);
        end
        tx_full = 1'b0;
        #1 chk("bp_ready_go", 32'(Ready), 2);
        tick();
        chk("bp_wr",   32'(write_to_uart), 1);
        chk("bp_data", 32'(uart_data), 'h5A);
        clr_in();
        tick();

        // Idle timeout on requester 2
        do_reset();
        Request = 3'b100;
        tick();
        chk("to_grant", 32'(Grant), 4);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("to_early", {30'd0, TimeoutFlag, Grant[2]}, 1);
        end
        tick();
        chk("to_flag",  32'(TimeoutFlag), 1);
        chk("to_clear", 32'(Grant), 0);
        Request = 3'b111;
        tick();
        chk("to_pulse", 32'(TimeoutFlag), 0);
        chk("to_gap",   32'(Grant), 0);
        tick();
        chk("to_next",  32'(Grant), 1);
        Request = 3'b000;
        tick();
        chk("drop_rel", 32'(Grant), 0);
        chk("drop_nowr", 32'(write_to_uart), 0);
        tick();

        // Asynchronous reset with a write in flight
        do_reset();
        Request = 3'b001; Valid = 3'b001; Data0 = 8'h77;
        tick();
        tick();
        chk("ar_wr", 32'(write_to_uart), 1);
        Reset = 1'b0;
        #1;
        chk("ar_outs", {20'd0, Grant, Ready, write_to_uart, TimeoutFlag, Busy, 3'd0}, 0);
        chk("ar_data", 32'(uart_data), 0);
        Request = 3'b110; Valid = '0;
        tick();
        chk("ar_hold", 32'(write_to_uart), 0);
        Reset = 1'b1;
        tick();
        chk("ar_first", 32'(Grant), 2);
        clr_in();
        tick();
        tick();

        // Last acceptance coinciding with timeout limit and request drop
        do_reset();
        Request = 3'b001;
        tick();
        repeat (15) tick();
        Valid = 3'b001; Last = 3'b001; Data0 = 8'hC3; Request = 3'b000;
        #1 chk("co_ready", 32'(Ready), 1);
        tick();
        chk("co_wr",   32'(write_to_uart), 1);
        chk("co_data", 32'(uart_data), 'hC3);
        chk("co_tf",   32'(TimeoutFlag), 0);
        chk("co_rel",  {30'd0, Busy, |Grant}, 2);
        clr_in();
        tick();
        chk("co_end",  {29'd0, write_to_uart, TimeoutFlag, Busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, character width in bits.
REQ-002 Parameter IDLE_TIMEOUT, default 16, maximum SEND cycles without an accepted character before forced release; legal range 2..255.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Request  input  3  per-requester message request; bit i belongs to requester i.
REQ-006 Valid  input  3  per-requester character valid.
REQ-007 Last  input  3  per-requester final-character marker; qualified by Valid.
REQ-008 Data0, Data1, Data2  input  DATA_WIDTH each  character from requester 0, 1 and 2.
REQ-009 tx_full  input  1  UART transmit FIFO full.
REQ-010 Grant  output  3  registered, one-hot or zero; current owner of the UART.
REQ-011 Ready  output  3  combinational; bit i high when requester i's character is accepted this cycle.
REQ-012 write_to_uart  output  1  registered single-cycle FIFO write strobe.
REQ-013 uart_data  output  DATA_WIDTH  registered character presented with write_to_uart.
REQ-014 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 TimeoutFlag  output  1  registered single-cycle pulse on forced release.

Function
REQ-016 The FSM SHALL have the states IDLE, SEND and RELEASE.
REQ-017 IDLE: when any Request bit is high, the block SHALL select one requester by round-robin, searching from pointer index upward modulo 3, set Grant to that requester one-hot and enter SEND on the next edge.
REQ-018 Acceptance SHALL occur in SEND only when Valid[g] is high, tx_full is low and write_to_uart is low; at most one character is accepted every two cycles.
REQ-019 Ready[g] SHALL equal the acceptance condition; Ready SHALL be 0 for non-granted requesters and in every other state.
REQ-020 On acceptance, write_to_uart SHALL be 1 and uart_data SHALL equal Data_g on the following cycle; otherwise write_to_uart SHALL be 0 and uart_data SHALL hold its value.
REQ-021 Acceptance with Last[g] high SHALL move the FSM to RELEASE.
REQ-022 In SEND, Request[g] going low without an accepted Last SHALL move the FSM to RELEASE with no further write.
REQ-023 An 8-bit idle counter SHALL clear on entry to SEND and on each acceptance, and SHALL increment on every other SEND cycle.
REQ-024 When the idle counter reaches IDLE_TIMEOUT-1 without acceptance, the block SHALL pulse TimeoutFlag for one cycle and enter RELEASE.
REQ-025 RELEASE SHALL last exactly one cycle: Grant cleared, pointer set to (g+1) mod 3, then IDLE.
REQ-026 If a Last acceptance, a Request drop and a timeout coincide, acceptance SHALL take priority: the character is written, TimeoutFlag stays 0, and the FSM enters RELEASE.
REQ-027 The minimum gap between two grants SHALL be 2 cycles (RELEASE, then IDLE arbitration).
REQ-028 A requester SHALL NOT be granted twice in a row while another Request bit is high in IDLE.

Reset
REQ-029 While Reset is low, the block SHALL force state IDLE, Grant=0, write_to_uart=0, uart_data=0, TimeoutFlag=0, pointer=0 and idle counter=0, independent of Clock.
REQ-030 Reset asserted mid-message SHALL abandon the message without a further write; after release, the first arbitration SHALL start from requester 0.

Verification
REQ-031 Request=3'b001, requester 0 sends "A","B" (Last on "B"), tx_full=0 -> write_to_uart pulses carry 8'h41 then 8'h42, two cycles apart; Grant=001 then 000 after RELEASE.
REQ-032 Request=3'b111 held, each message is one character with Last -> grants in order 001, 010, 100, 001.
REQ-033 Requester 1 granted, tx_full=1 for 5 cycles while Valid=1 -> Ready=0 and no write for 5 cycles; the character is written one cycle after tx_full falls.
REQ-034 Requester 2 granted, Valid held 0, IDLE_TIMEOUT=16 -> TimeoutFlag pulses 16 cycles after SEND entry, Grant clears, next grant goes to requester 0.
REQ-035 Reset driven low mid-message with write pending -> all outputs 0 immediately; after reset release with Request=3'b110, the first grant is 010.
REQ-036 Last accepted on the same cycle the idle counter hits its limit and Request drops -> one write, TimeoutFlag=0, RELEASE next cycle.
